// File: rtl/fe_decode_queue.sv
// fe_decode_queue: in-order FIFO between decode and rename, flushed on mispredict.
// Optional same-cycle bypass when empty: define FE_DECODE_QUEUE_BYPASS_EN.
module fe_decode_queue #(
  parameter int WIDTH_P       = 32,
  parameter int DEPTH_P       = 8,
  parameter int ALMOST_FULL_P = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [WIDTH_P-1:0]         data_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [WIDTH_P-1:0]         data_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH_P):0]   count_o,
  output logic                       almost_full_o
);

  localparam int AW = $clog2(DEPTH_P);
  localparam int CW = AW + 1;

  logic [WIDTH_P-1:0] mem_q [DEPTH_P];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      free_w;

  logic full_w;
  logic empty_w;
  logic push_w;
  logic pop_w;
  logic wr_en_w;

  assign full_w  = (count_q == CW'(DEPTH_P));
  assign empty_w = (count_q == '0);
  assign free_w  = CW'(DEPTH_P) - count_q;

  assign ready_o       = ~full_w & reset_n_i;
  assign count_o       = count_q;
  assign almost_full_o = (free_w <= CW'(ALMOST_FULL_P));

`ifdef FE_DECODE_QUEUE_BYPASS_EN
  logic byp_w;

  // Empty queue forwards the incoming entry straight to rename.
  assign byp_w   = empty_w & valid_i & ~flush_i & reset_n_i;
  assign valid_o = (~empty_w | byp_w) & ~flush_i & reset_n_i;
  assign data_o  = empty_w ? data_i : mem_q[rd_ptr_q];
  assign push_w  = valid_i & ready_o & ~flush_i;
  assign pop_w   = valid_o & ready_i & ~empty_w;
  assign wr_en_w = push_w & ~(byp_w & ready_i);
`else
  assign valid_o = ~empty_w & ~flush_i & reset_n_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_w  = valid_i & ready_o & ~flush_i;
  assign pop_w   = valid_o & ready_i;
  assign wr_en_w = push_w;
`endif

  // Next-state pointers and occupancy; flush empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_w) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_w)   rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_en_w, pop_w})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && wr_en_w) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

`ifndef SYNTHESIS
  // Protocol sanity checks on the registered state.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(wr_en_w && full_w))
        else $error("push into full queue");
      assert (!(pop_w && empty_w))
        else $error("pop from empty queue");
      assert (count_q <= CW'(DEPTH_P))
        else $error("count overflow");
    end
  end
`endif

endmodule

// File: tb/tb_fe_decode_queue.sv
// tb_fe_decode_queue: randomized scoreboard bench for fe_decode_queue.
// Expected entries queued at issue; a negedge monitor pops and compares.
module tb_fe_decode_queue;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 2;
`ifdef FE_DECODE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         vin = 1'b0;
  logic [W-1:0] din = '0;
  logic         rdy_o;
  logic         vout;
  logic [W-1:0] dout;
  logic         rdy_in = 1'b0;
  logic [3:0]   cnt;
  logic         afull;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  int  cnt_now = 0;
  int  cnt_nxt = 0;
  bit  e_ready = 0;
  bit  e_valid = 0;
  bit  chk_en  = 0;

  always #5 clk = ~clk;

  fe_decode_queue #(
    .WIDTH_P(W), .DEPTH_P(D), .ALMOST_FULL_P(AF)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .flush_i(flush),
    .valid_i(vin),
    .data_i(din),
    .ready_o(rdy_o),
    .valid_o(vout),
    .data_o(dout),
    .ready_i(rdy_in),
    .count_o(cnt),
    .almost_full_o(afull)
  );

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // One cycle: drive inputs after the edge and update the reference model.
  task automatic cyc(input bit r, input bit f, input bit v,
                     input logic [W-1:0] d, input bit rd);
    bit byp, push, pop;
    @(posedge clk); #1;
    cnt_now = cnt_nxt;
    reset_n = r; flush = f; vin = v; din = d; rdy_in = rd;
    byp     = BYP && cnt_now == 0 && v && !f && r;
    e_ready = r && cnt_now < D;
    e_valid = r && !f && (cnt_now > 0 || byp);
    push    = v && e_ready && !f;
    pop     = e_valid && rd;
    if (!r || f) begin
      exp_q.delete();
      cnt_nxt = 0;
    end else begin
      if (push) exp_q.push_back(d);
      cnt_nxt = cnt_now + int'(push) - int'(pop);
    end
    chk_en = 1;
  endtask

  // Monitor: compare outputs against the model at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_o", int'(rdy_o), int'(e_ready));
      chk("valid_o", int'(vout), int'(e_valid));
      chk("count_o", int'(cnt), cnt_now);
      chk("almost_full_o", int'(afull), int'((D - cnt_now) <= AF));
      if (vout && rdy_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          chk("data_o", int'(dout), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 0);
    // three tags held, then drained
    cyc(1, 0, 1, 8'h11, 0);
    cyc(1, 0, 1, 8'h22, 0);
    cyc(1, 0, 1, 8'h33, 0);
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h00, 1);
    // fill, refuse ninth, push+pop when full
    for (int i = 0; i < 9; i++) cyc(1, 0, 1, 8'h40 + 8'(i), 0);
    cyc(1, 0, 1, 8'h4F, 1);
    cyc(1, 0, 0, 8'h00, 0);
    // reset with entries held
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 8'h60 + 8'(i), 0);
    cyc(0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 0);
    // streaming across pointer wrap
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, 8'(i), 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h00, 1);
    // flush with four held and a colliding push
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 8'h70 + 8'(i), 0);
    cyc(1, 1, 1, 8'hAA, 0);
    cyc(1, 0, 0, 8'h00, 1);
    cyc(1, 0, 0, 8'h00, 1);
    // bypass candidates on empty queue
    cyc(1, 0, 1, 8'h5A, 1);
    cyc(1, 0, 0, 8'h00, 0);
    cyc(1, 0, 1, 8'h5B, 0);
    cyc(1, 0, 0, 8'h00, 1);
    cyc(1, 0, 0, 8'h00, 1);
    // flush during reset
    cyc(0, 1, 1, 8'h99, 1);
    cyc(1, 0, 0, 8'h00, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0),
          8'($urandom),
          ($urandom_range(0, 2) != 0));
    end
    cyc(1, 0, 0, 8'h00, 1);
    @(posedge clk); #1;
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
